// File: rtl/serial_pkg.sv
// Shared definitions for the UART-style serial receiver: state encodings,
// default bit timing and the error counter ceiling.
package serial_pkg;

  localparam int         CLKS_PER_BIT_DEFAULT = 434;
  localparam logic [7:0] ERR_COUNT_MAX        = 8'd255;

  typedef enum logic [7:0] {
    IDLE      = 8'h00,
    START     = 8'h01,
    DATA      = 8'h02,
    PARITY    = 8'h03,
    STOP      = 8'h04,
    WAIT_HIGH = 8'h05
  } rx_state_e;

endpackage

// File: rtl/serial_receiver_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops load
// RESET_VALUE under synchronous reset.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments make both flops sample their pre-edge
  // inputs; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serial_receiver.sv
// 8N1 serial receiver with mid-bit sampling, framing/parity error pulses and a
// saturating error counter. Define SERIAL_RECEIVER_PARITY_EN for 8E1 frames.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_available,
  output logic       framing_error,
  output logic       parity_error,
  output logic [7:0] error_count
);

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  rx_state_e   state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        avail_q, avail_d;
  logic        ferr_q, ferr_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [1:0]  flush_q, flush_d;
  logic        armed_q, armed_d;
  logic        rxs;
  logic        half_sample, bit_sample, stop_sample, parity_bad;

  sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rxs)
  );

  assign half_sample = (timer_q == HALF_LAST);
  assign bit_sample  = (timer_q == BIT_LAST);
  assign stop_sample = (state_q == STOP) && bit_sample;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (armed_q && !rxs) state_d = START;
      START:     if (half_sample) state_d = rxs ? IDLE : DATA;
      DATA: begin
        if (bit_sample && bit_idx_q == 3'd7) begin
`ifdef SERIAL_RECEIVER_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef SERIAL_RECEIVER_PARITY_EN
      PARITY:    if (bit_sample) state_d = STOP;
`endif
      STOP:      if (bit_sample) state_d = rxs ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (bit_sample && rxs) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

`ifdef SERIAL_RECEIVER_PARITY_EN
  logic parity_bad_q, parity_bad_d, perr_q, perr_d;

  always_comb begin
    parity_bad_d = parity_bad_q;
    if (state_q == IDLE)                    parity_bad_d = 1'b0;
    else if (state_q == PARITY && bit_sample) parity_bad_d = (^shift_q) ^ rxs;
    perr_d = stop_sample && rxs && parity_bad_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_bad_q <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      parity_bad_q <= parity_bad_d;
      perr_q       <= perr_d;
    end
  end

  assign parity_bad   = parity_bad_q;
  assign parity_error = perr_q;
`else
  logic perr_d;
  assign parity_bad   = 1'b0;
  assign perr_d       = 1'b0;
  assign parity_error = 1'b0;
`endif

  always_comb begin
    timer_d   = timer_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    // A start edge is only honoured once the synchronizer holds real line
    // data showing high, so a frame already running at reset is dropped.
    flush_d   = {flush_q[0], 1'b1};
    armed_d   = armed_q | (flush_q[1] & rxs);

    if (state_q == IDLE || state_d != state_q || bit_sample ||
        (state_q == WAIT_HIGH && !rxs))
      timer_d = '0;

    if (state_q != DATA) begin
      bit_idx_d = '0;
    end else if (bit_sample) begin
      shift_d   = {rxs, shift_q[7:1]};
      bit_idx_d = bit_idx_q + 3'd1;
    end

    avail_d   = stop_sample && rxs && !parity_bad;
    ferr_d    = stop_sample && !rxs;
    byte_d    = avail_d ? shift_q : byte_q;
    err_cnt_d = err_cnt_q;
    if ((ferr_d || perr_d) && err_cnt_q != ERR_COUNT_MAX)
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      avail_q   <= 1'b0;
      ferr_q    <= 1'b0;
      err_cnt_q <= '0;
      flush_q   <= '0;
      armed_q   <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      avail_q   <= avail_d;
      ferr_q    <= ferr_d;
      err_cnt_q <= err_cnt_d;
      flush_q   <= flush_d;
      armed_q   <= armed_d;
    end
  end

  assign byte_out       = byte_q;
  assign byte_available = avail_q;
  assign framing_error  = ferr_q;
  assign error_count    = err_cnt_q;

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: frames are driven bit by bit, expected
// pulses are queued when a frame starts and matched by a negedge monitor.
`timescale 1ns/1ps
module tb_serial_receiver;

  localparam int         CPB    = 16;
  localparam logic [2:0] K_BYTE = 3'b100;
  localparam logic [2:0] K_FERR = 3'b010;
  localparam logic [2:0] K_PERR = 3'b001;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] byte_out;
  logic       byte_available;
  logic       framing_error;
  logic       parity_error;
  logic [7:0] error_count;
  logic [2:0] pulses;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_byte;
  logic [7:0] err_model;
`ifdef SERIAL_RECEIVER_PARITY_EN
  logic       flip_parity = 1'b0;
`endif

  always #5 clk = ~clk;

  serial_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx             (rx),
    .byte_out       (byte_out),
    .byte_available (byte_available),
    .framing_error  (framing_error),
    .parity_error   (parity_error),
    .error_count    (error_count)
  );

  assign pulses = {byte_available, framing_error, parity_error};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every pulse cycle consumes one scoreboard entry, so a stretched pulse or
  // an unannounced one shows up as a kind mismatch or an empty queue.
  always @(negedge clk) begin
    if (rst) begin
      last_byte = 8'h00;
      err_model = 8'h00;
    end else if (pulses != 3'b000) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 16'(pulses), 16'h0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind", 16'(pulses), 16'(mon_e.kind));
        if (mon_e.kind == K_BYTE) begin
          check("byte_out", 16'(byte_out), 16'(mon_e.data));
          last_byte = mon_e.data;
        end else begin
          if (err_model != 8'd255) err_model = err_model + 8'd1;
          check("byte_out_held_on_error", 16'(byte_out), 16'(last_byte));
        end
        check("error_count_at_pulse", 16'(error_count), 16'(err_model));
      end
    end else begin
      check("byte_out_stable", 16'(byte_out), 16'(last_byte));
    end
  end

  task automatic idle(input int cycles);
    rx = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    exp_t e;
    if (!stop_bit) e = '{kind: K_FERR, data: 8'h00};
`ifdef SERIAL_RECEIVER_PARITY_EN
    else if (flip_parity) e = '{kind: K_PERR, data: 8'h00};
`endif
    else e = '{kind: K_BYTE, data: data};
    sb.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef SERIAL_RECEIVER_PARITY_EN
    send_bit((^data) ^ flip_parity);
`endif
    send_bit(stop_bit);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_out"}, 16'(byte_out), 16'h00);
    check({tag, "_avail"}, 16'(byte_available), 16'h0);
    check({tag, "_ferr"}, 16'(framing_error), 16'h0);
    check({tag, "_perr"}, 16'(parity_error), 16'h0);
    check({tag, "_errcnt"}, 16'(error_count), 16'h00);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(CPB * 2);

    // Back-to-back frames with no idle gap.
    send_frame(8'h4C, 1'b1);
    send_frame(8'h33, 1'b1);
    idle(CPB * 2);
    check("b2b_drained", 16'(sb.size()), 16'h0);
    check("b2b_byte", 16'(byte_out), 16'h33);
    check("b2b_errcnt", 16'(error_count), 16'h00);

    // Short low glitch must not start a frame.
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle(CPB * 4);
    check("glitch_drained", 16'(sb.size()), 16'h0);
    check("glitch_byte", 16'(byte_out), 16'h33);

    // Bad stop bit, then a clean frame.
    send_frame(8'hA5, 1'b0);
    idle(CPB * 2);
    check("ferr_byte_kept", 16'(byte_out), 16'h33);
    check("ferr_errcnt", 16'(error_count), 16'h01);
    send_frame(8'h46, 1'b1);
    idle(CPB * 2);
    check("after_ferr_byte", 16'(byte_out), 16'h46);
    check("after_ferr_drained", 16'(sb.size()), 16'h0);

`ifdef SERIAL_RECEIVER_PARITY_EN
    flip_parity = 1'b1;
    send_frame(8'h41, 1'b1);
    idle(CPB * 2);
    check("perr_byte_kept", 16'(byte_out), 16'h46);
    check("perr_errcnt", 16'(error_count), 16'h02);
    send_frame(8'h41, 1'b0);
    idle(CPB * 2);
    flip_parity = 1'b0;
    check("both_faults_errcnt", 16'(error_count), 16'h03);
    check("parity_drained", 16'(sb.size()), 16'h0);
`endif

    // Reset in the middle of data bit 4 of 0x30, held to the end of the frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
`ifdef SERIAL_RECEIVER_PARITY_EN
    send_bit(1'b0);
`endif
    send_bit(1'b1);
    check_reset_outputs("midframe_rst");
    rst = 1'b0;
    idle(CPB * 2);
    check("midframe_errcnt", 16'(error_count), 16'h00);

    // Line already low when reset releases: ignored until it returns high.
    rst = 1'b1;
    rx  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    idle(CPB * 4);
    check("low_at_release_drained", 16'(sb.size()), 16'h0);
    check("low_at_release_byte", 16'(byte_out), 16'h00);

    send_frame(8'h30, 1'b1);
    idle(CPB * 2);
    check("post_reset_byte", 16'(byte_out), 16'h30);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      send_frame(8'h00, 1'b0);
      idle(CPB * 2);
    end
    check("sat_errcnt", 16'(error_count), 16'hFF);
    check("sat_drained", 16'(sb.size()), 16'h0);
    send_frame(8'h5A, 1'b1);
    idle(CPB * 2);
    check("sat_then_byte", 16'(byte_out), 16'h5A);
    check("sat_hold", 16'(error_count), 16'hFF);
    check("final_drained", 16'(sb.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per bit period (50 MHz / 115200); legal range 16..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high, 8 data bits LSB first, 1 stop bit.
REQ-005 SHALL have port byte_out  output  8  last good received byte; feeds input_handler byte_in.
REQ-006 SHALL have port byte_available  output  1  one-cycle pulse marking a new byte_out; feeds input_handler byte_available.
REQ-007 SHALL have port framing_error  output  1  one-cycle pulse on a bad stop bit.
REQ-008 SHALL have port parity_error  output  1  one-cycle pulse on a parity mismatch.
REQ-009 SHALL have port error_count  output  8  saturating count of framing plus parity errors.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-012 IDLE: on rxs low, SHALL go to START and clear the bit-timer.
REQ-013 START: at timer = CLKS_PER_BIT/2 - 1 (integer division), rxs low SHALL go to DATA; rxs high (glitch) SHALL return to IDLE with no output. The timer SHALL restart at every state entry and at every bit sample.
REQ-014 DATA: SHALL sample one bit per CLKS_PER_BIT cycles at mid-bit, shifting into an 8-bit register LSB first; after bit 7 SHALL go to PARITY if enabled, else STOP.
REQ-015 STOP: at mid-bit, rxs high and no parity fault SHALL load byte_out and pulse byte_available the next cycle, then go to IDLE.
REQ-016 STOP: rxs low SHALL pulse framing_error, leave byte_out unchanged, and go to WAIT_HIGH.
REQ-017 WAIT_HIGH: SHALL return to IDLE only after rxs has been high for one full bit period (break tolerance).
REQ-018 byte_out SHALL hold stable between byte_available pulses; input_handler samples it one cycle after the pulse edge.
REQ-019 byte_available SHALL be exactly 1 cycle wide; back-to-back frames with no idle gap SHALL each produce a pulse.
REQ-020 error_count SHALL increment by 1 per error pulse and saturate at 255 without wrapping. A simultaneous framing and parity fault SHALL count once and report framing_error only.
REQ-021 Latency SHALL be: stop-bit mid-sample to byte_available high = 1 cycle.

Reset
REQ-022 rst SHALL force IDLE and set byte_out=0, byte_available=0, framing_error=0, parity_error=0, error_count=0, synchronizer flops=1, and timer and bit index to 0.
REQ-023 rst asserted mid-frame SHALL abort the frame with no pulse. A frame whose start edge began during reset SHALL be ignored until rxs returns high.

Configuration
REQ-024 SHALL use macro SERIAL_RECEIVER_PARITY_EN.
REQ-025 With SERIAL_RECEIVER_PARITY_EN defined, SHALL sample an even-parity bit in PARITY at mid-bit. On mismatch, SHALL pulse parity_error in the STOP decision cycle and suppress byte_available and the byte_out update.
REQ-026 With SERIAL_RECEIVER_PARITY_EN undefined, SHALL omit the PARITY state (frame = 10 bits) and tie parity_error to 0.

Structure
REQ-027 Shared package serial_pkg SHALL hold the state encodings (8-bit, matching input_handler style), the default CLKS_PER_BIT, and the ERR_COUNT_MAX=255 constant.
REQ-028 SHALL instantiate one sub-module, sync_2ff (2-flop synchronizer, reset value parameterized to 1); all other logic stays in serial_receiver.

Verification
REQ-029 CLKS_PER_BIT=16, send 0x4C then 0x33 back-to-back -> two byte_available pulses, byte_out=0x4C then 0x33, error_count=0.
REQ-030 rx low pulse of 5 cycles from idle -> return to IDLE, no byte_available, no error pulse.
REQ-031 Send 0xA5 with stop bit forced low -> framing_error pulse, byte_out keeps its prior value, error_count=1; the next valid 0x46 is then received.
REQ-032 Parity enabled, send 0x41 with odd parity bit -> parity_error pulse, no byte_available, error_count=1.
REQ-033 Assert rst during data bit 4 of 0x30 -> no pulses, all outputs 0; a subsequent 0x30 is received correctly.
REQ-034 Force 300 framing errors -> error_count saturates at 255.
